pwm_multi_core: RTL

Parametrised multi-channel PWM generator, successor to the single-channel PWM core. One shared period counter drives N_CH compare channels, each with its own duty source, polarity and enable. It adds edge- and center-aligned modes and shadowed (glitch-free) period and duty updates. It sits between the register file and the pin mux; `o_period_end` is available to the interrupt/DMA logic.

---
 rtl/pwm_pkg.sv | 15 +
 rtl/pwm_channel.sv | 45 ++++
 rtl/pwm_multi_core.sv | 108 ++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM core.
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  localparam int N_CH_DEF  = 4;
  localparam int CNT_W_DEF = 16;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM compare channel: external duty capture, shadowed duty, compare,
// polarity/enable gating and the registered output.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt,
  input  logic             shadow_load,
  input  logic             active,
  input  logic [CNT_W-1:0] duty_reg,
  input  logic             duty_sel,
  input  logic [CNT_W-1:0] i_dc,
  input  logic             i_dc_valid,
  input  logic             ch_en,
  input  logic             pol,
  output logic             pwm
);

  logic [CNT_W-1:0] dc_hold;
  logic [CNT_W-1:0] duty_sh;
  logic             raw;

  assign raw = (cnt < duty_sh);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dc_hold <= '0;
      duty_sh <= '0;
      pwm     <= 1'b0;
    end else begin
      if (i_dc_valid) begin
        dc_hold <= i_dc;
      end
      // Shadow sees the pre-capture dc_hold when a capture coincides with a wrap.
      if (shadow_load) begin
        duty_sh <= duty_sel ? dc_hold : duty_reg;
      end
      pwm <= (active && ch_en) ? (raw ^ pol) : pol;
    end
  end

endmodule

// File: rtl/pwm_multi_core.sv
// Multi-channel PWM: shared edge/center-aligned period counter with shadowed
// period/mode, driving N_CH pwm_channel compare units.
module pwm_multi_core
  import pwm_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_en,
  input  logic                  cnt_en,
  input  logic                  mode,
  input  logic [CNT_W-1:0]      period_reg,
  input  logic [N_CH*CNT_W-1:0] duty_reg,
  input  logic [N_CH-1:0]       duty_sel,
  input  logic [N_CH*CNT_W-1:0] i_dc,
  input  logic [N_CH-1:0]       i_dc_valid,
  input  logic [N_CH-1:0]       ch_en,
  input  logic [N_CH-1:0]       pol,
  output logic [N_CH-1:0]       o_pwm,
  output logic                  o_period_end,
  output logic [CNT_W-1:0]      o_cnt
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] period_sh;
  logic             mode_sh;
  dir_t             dir_reg;
  dir_t             dir_next;
  logic             period_end_reg;
  logic             run;
  logic             wrap;
  logic             shadow_load;

  assign run = core_en && (period_sh != '0);

  always_comb begin
    cnt_next = cnt_reg;
    dir_next = dir_reg;
    if (!run) begin
      cnt_next = '0;
      dir_next = DIR_UP;
    end else if (cnt_en) begin
      if (mode_sh == MODE_EDGE) begin
        cnt_next = (cnt_reg >= period_sh - 1'b1) ? '0 : cnt_reg + 1'b1;
        dir_next = DIR_UP;
      end else if (dir_reg == DIR_UP && cnt_reg < period_sh) begin
        cnt_next = cnt_reg + 1'b1;
      end else begin
        cnt_next = cnt_reg - 1'b1;
        dir_next = DIR_DOWN;
      end
      if (cnt_next == '0) begin
        dir_next = DIR_UP;
      end
    end
  end

  // Disabled or zero-period cores reload shadows every cycle so that a
  // restart picks up the latest register values immediately.
  assign wrap        = cnt_en && (cnt_next == '0);
  assign shadow_load = wrap || !core_en || (period_sh == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg        <= '0;
      dir_reg        <= DIR_UP;
      period_sh      <= '0;
      mode_sh        <= MODE_EDGE;
      period_end_reg <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      dir_reg        <= dir_next;
      period_end_reg <= run && wrap;
      if (shadow_load) begin
        period_sh <= period_reg;
        mode_sh   <= mode;
      end
    end
  end

  assign o_cnt        = cnt_reg;
  assign o_period_end = period_end_reg;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      pwm_channel #(
        .CNT_W(CNT_W)
      ) u_ch (
        .clk        (clk),
        .rst        (rst),
        .cnt        (cnt_reg),
        .shadow_load(shadow_load),
        .active     (run),
        .duty_reg   (duty_reg[gi*CNT_W +: CNT_W]),
        .duty_sel   (duty_sel[gi]),
        .i_dc       (i_dc[gi*CNT_W +: CNT_W]),
        .i_dc_valid (i_dc_valid[gi]),
        .ch_en      (ch_en[gi]),
        .pol        (pol[gi]),
        .pwm        (o_pwm[gi])
      );
    end
  endgenerate

endmodule
